iic_slave: RTL and testbench
============================

# iic_slave

I2C target (responder) that answers the team's `iic_ctrl` master on the same two-wire bus. It is a byte-addressed register file with a 7-bit device address and an 8-bit word address, and supports byte/page write, current-address read, random read (via repeated START) and sequential read. It serves as the on-board EEPROM stand-in for simulation and as a real target for the FPGA's own I2C master. Every accepted write is also reported on a strobe port for downstream logic.

## Interface
- `DEV_ADDR`, default 7'h50: 7-bit device address this target answers to.
- `DEPTH`, default 256: register file bytes; power of two, ≤256.
- `s_clk` in, 1 bit: system clock, 50 MHz; bus is oversampled, with SCL ≤ s_clk/16.
- `s_rst` in, 1 bit: synchronous, active-high reset.
- `scl` in, 1 bit: bus clock from the master, asynchronous to `s_clk`.
- `sda_in` in, 1 bit: SDA pad readback, asynchronous.
- `sda_oe` out, 1 bit: 1 drives SDA low (open-drain); 0 releases SDA.
- `wr_en` out, 1 bit: one-cycle pulse per byte written.
- `wr_addr` out, 8 bits: word address of that byte.
- `wr_data` out, 8 bits: data of that byte.
- `busy` out, 1 bit: high from an addressed START until STOP or NACK release.

## Operation
- Input path: `scl` and `sda_in` each pass through a 2-FF synchronizer plus one history FF. Edge flags come from the last two sampled values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in any state.
- Bits are sampled on SCL rising. `sda_oe` changes only on SCL falling.
- FSM states and transitions:
  - `IDLE`: on START, go to `DEV`.
  - `DEV`: shift 8 bits MSB first. If [7:1]==DEV_ADDR, go to `DEV_ACK`; otherwise go to `IDLE` with SDA released.
  - `DEV_ACK`: drive ACK for one SCL period. If R/W=0, go to `WADDR`; if R/W=1, go to `RD`.
  - `WADDR`: shift 8 bits, load the pointer, then `WADDR_ACK` → `WR`.
  - `WR`: shift 8 bits, write mem[ptr], pulse `wr_en`, then `WR_ACK` → `WR`.
  - `RD`: drive mem[ptr] MSB first, then `RD_MACK`. Master ACK (SDA low) → `RD`; master NACK → `IDLE`.
- Pointer arithmetic: 8-bit register, wraps modulo DEPTH. It increments after each written byte and after each read byte. Unused address MSBs are ignored.
- Repeated START in any state: go to `DEV` and keep the pointer. This is how random read works.
- STOP in any state: go to `IDLE`, release SDA, drop `busy`. A partial byte is discarded and no write occurs.
- Read prefetch: mem[ptr] is latched into the shift register in the cycle `DEV_ACK` or `RD_MACK` completes.

## Timing
- Reset values: `sda_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, state `IDLE`, pointer 0.
- Reset does not clear memory.
- Pad-to-event latency is 3 `s_clk` cycles: 2 sync + 1 edge.
- The ACK/data drive asserts 1 cycle after the detected SCL fall, i.e. 4 cycles after the pad edge.
- `wr_en` pulses 1 cycle after the SCL rise of bit 0 is detected.
- `wr_addr`/`wr_data` are valid with `wr_en` and hold until the next write.
- `busy` rises with the `DEV_ACK` entry and falls 1 cycle after STOP or master NACK.
- START and SCL edge in the same cycle cannot occur, because SDA is stable while SCL is high. START takes priority if it is ever flagged.
- Reset asserted mid-transfer: the block returns to `IDLE` next cycle with SDA released. It then ignores the bus until the next START.

## Configuration
- `IIC_SLAVE_AUTOINC_EN`:
  - Defined: the pointer auto-increments as above.
  - Undefined: the pointer changes only in `WADDR`. Sequential reads return the same byte repeatedly, and page writes overwrite one location.

## Structure
- Shared package `iic_pkg`:
  - state enum `iic_slv_state_t`;
  - constants `IIC_ACK`=1'b0 and `IIC_NACK`=1'b1;
  - `IIC_RW_READ`=1'b1.
- Sub-module `iic_bus_sync`: 2-FF synchronizers plus the START/STOP/SCL-rise/SCL-fall detector, reusable by `iic_ctrl`.
- Register file: inferred single-port RAM inside `iic_slave`.

## Test plan
- Write dev 0x50, addr 0x10, data 0xA5, STOP:
  - three ACKs;
  - `wr_en` pulse with `wr_addr`=0x10, `wr_data`=0xA5;
  - `busy` low after STOP.
- Random read: dev 0x50 W, addr 0x10, repeated START, dev 0x50 R, master NACK:
  - SDA carries 0xA5;
  - target releases SDA;
  - state returns to `IDLE`.
- Dev address 0x51 → no ACK, `sda_oe` stays 0, no `wr_en`, `busy` stays 0.
- Page write 0x11,0x22,0x33 at addr 0xFE with DEPTH=256, then sequential read of 3 bytes from 0xFE:
  - with `IIC_SLAVE_AUTOINC_EN`: 0x11,0x22,0x33 (wrap to 0x00);
  - without it: read returns 0x33 three times.
- STOP after 4 data bits of a write → no `wr_en`, memory unchanged, `IDLE`.
- `s_rst` pulsed during `RD` while `sda_oe`=1 → `sda_oe`=0 next cycle. A subsequent full write transaction completes normally.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared I2C definitions for the iic_slave target and the iic_ctrl master.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WR, WR_ACK, RD, RD_MACK
    } iic_slv_state_t;

    localparam logic IIC_ACK     = 1'b0;
    localparam logic IIC_NACK    = 1'b1;
    localparam logic IIC_RW_READ = 1'b1;

endpackage

// File: rtl/iic_bus_sync.sv
// Two-FF synchronizers for SCL/SDA plus a history stage for edge and
// START/STOP detection. Flags are valid for one clock.
module iic_bus_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // [0],[1] synchronize, [2] holds the previous synchronized value
    logic [2:0] r_scl;
    logic [2:0] r_sda;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl <= '1;
            r_sda <= '1;
        end else begin
            r_scl <= {r_scl[1:0], i_scl};
            r_sda <= {r_sda[1:0], i_sda};
        end
    end

    assign o_sda      = r_sda[1];
    assign o_scl_rise =  r_scl[1] & ~r_scl[2];
    assign o_scl_fall = ~r_scl[1] &  r_scl[2];
    assign o_start    =  r_scl[1] &  r_scl[2] & ~r_sda[1] &  r_sda[2];
    assign o_stop     =  r_scl[1] &  r_scl[2] &  r_sda[1] & ~r_sda[2];

endmodule

// File: rtl/iic_slave.sv
// I2C target with byte-addressed register file; write strobe on every stored byte.
// IIC_SLAVE_AUTOINC_EN: when defined, the pointer advances after each byte.
module iic_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int          DEPTH    = 256
) (
    input  logic       s_clk,
    input  logic       s_rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] PTR_MASK = 8'(DEPTH - 1);
`ifdef IIC_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic w_sda, w_rise, w_fall, w_start, w_stop;

    iic_bus_sync u_sync (
        .i_clk      (s_clk),
        .i_rst      (s_rst),
        .i_scl      (scl),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    iic_slv_state_t r_state, w_state;
    logic [2:0] r_bitcnt, w_bitcnt;
    logic       r_phase, w_phase;   // ACK states: ACK driven; RD/RD_MACK: byte/ack done
    logic [7:0] r_shift, w_shift;
    logic [7:0] r_ptr, w_ptr;
    logic       r_sda_oe, w_sda_oe;
    logic       r_busy, w_busy;
    logic       r_wr_en, w_wr_en;
    logic [7:0] r_wr_addr, w_wr_addr;
    logic [7:0] r_wr_data, w_wr_data;
    logic       w_mem_we;
    logic [7:0] w_rdata, w_byte, w_ptr_inc;

    logic [7:0] r_mem [DEPTH];

    assign w_rdata   = r_mem[r_ptr[AW-1:0]];
    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_ptr_inc = AUTOINC ? ((r_ptr + 8'd1) & PTR_MASK) : r_ptr;

    always_comb begin
        w_state   = r_state;
        w_bitcnt  = r_bitcnt;
        w_phase   = r_phase;
        w_shift   = r_shift;
        w_ptr     = r_ptr;
        w_sda_oe  = r_sda_oe;
        w_busy    = r_busy;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_mem_we  = 1'b0;
        if (w_start) begin
            w_state  = DEV;
            w_bitcnt = '0;
            w_phase  = 1'b0;
            w_sda_oe = 1'b0;
        end else if (w_stop) begin
            w_state  = IDLE;
            w_bitcnt = '0;
            w_phase  = 1'b0;
            w_sda_oe = 1'b0;
            w_busy   = 1'b0;
        end else begin
            case (r_state)
                DEV, WADDR, WR: if (w_rise) begin
                    w_shift  = w_byte;
                    w_bitcnt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        case (r_state)
                            DEV: if (w_byte[7:1] == DEV_ADDR) begin
                                w_state = DEV_ACK;
                                w_busy  = 1'b1;
                            end else begin
                                w_state = IDLE;
                                w_busy  = 1'b0;
                            end
                            WADDR: begin
                                w_ptr   = w_byte & PTR_MASK;
                                w_state = WADDR_ACK;
                            end
                            default: begin
                                w_mem_we  = 1'b1;
                                w_wr_en   = 1'b1;
                                w_wr_addr = r_ptr;
                                w_wr_data = w_byte;
                                w_ptr     = w_ptr_inc;
                                w_state   = WR_ACK;
                            end
                        endcase
                    end
                end
                DEV_ACK, WADDR_ACK, WR_ACK: if (w_fall) begin
                    if (!r_phase) begin
                        w_sda_oe = ~IIC_ACK;
                        w_phase  = 1'b1;
                    end else begin
                        w_phase  = 1'b0;
                        w_sda_oe = 1'b0;
                        if (r_state == DEV_ACK && r_shift[0] == IIC_RW_READ) begin
                            w_state  = RD;
                            w_shift  = w_rdata;
                            w_sda_oe = ~w_rdata[7];
                        end else begin
                            w_state = (r_state == DEV_ACK) ? WADDR : WR;
                        end
                    end
                end
                RD: if (w_rise) begin
                    w_bitcnt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_phase = 1'b1;
                end else if (w_fall) begin
                    if (r_phase) begin
                        w_phase  = 1'b0;
                        w_sda_oe = 1'b0;
                        w_ptr    = w_ptr_inc;
                        w_state  = RD_MACK;
                    end else begin
                        w_shift  = {r_shift[6:0], 1'b0};
                        w_sda_oe = ~r_shift[6];
                    end
                end
                RD_MACK: if (w_rise) begin
                    if (w_sda == IIC_NACK) begin
                        w_state = IDLE;
                        w_busy  = 1'b0;
                    end else begin
                        w_phase = 1'b1;
                    end
                end else if (w_fall && r_phase) begin
                    w_phase  = 1'b0;
                    w_bitcnt = '0;
                    w_state  = RD;
                    w_shift  = w_rdata;
                    w_sda_oe = ~w_rdata[7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_state   <= IDLE;
            r_bitcnt  <= '0;
            r_phase   <= 1'b0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state;
            r_bitcnt  <= w_bitcnt;
            r_phase   <= w_phase;
            r_shift   <= w_shift;
            r_ptr     <= w_ptr;
            r_sda_oe  <= w_sda_oe;
            r_busy    <= w_busy;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge s_clk) begin
        if (w_mem_we) r_mem[r_ptr[AW-1:0]] <= w_byte;
    end

    assign sda_oe  = r_sda_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;

endmodule

// File: tb/tb_iic_slave.sv
// Bus-level bench for iic_slave: bit-banged master plus a transaction-level memory model.
`timescale 1ns/1ps
module tb_iic_slave;
    import iic_pkg::*;

    localparam int Q = 8;
`ifdef IIC_SLAVE_AUTOINC_EN
    localparam int AI = 1;
`else
    localparam int AI = 0;
`endif

    logic s_clk = 1'b0, s_rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
    logic sda_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data;
    wire  sda_line = m_sda & ~sda_oe;

    always #5 s_clk = ~s_clk;

    iic_slave dut (
        .s_clk   (s_clk),
        .s_rst   (s_rst),
        .scl     (m_scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    int total = 0, bad = 0;
    logic [7:0]  mmem [256];
    int          mptr = 0;
    logic [15:0] wq[$];
    bit          oe_seen = 1'b0;
    logic [7:0]  tx [8];

    always @(negedge s_clk) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic hw(input int n);
        repeat (n) @(negedge s_clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; hw(Q); m_scl = 1'b1; hw(Q); m_sda = 1'b0; hw(Q); m_scl = 1'b0; hw(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; hw(Q); m_scl = 1'b1; hw(Q); m_sda = 1'b1; hw(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; hw(Q); m_scl = 1'b1; hw(Q); m_scl = 1'b0; hw(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; hw(Q); m_scl = 1'b1; hw(Q/2); b = sda_line; hw(Q/2); m_scl = 1'b0; hw(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(mack);
    endtask

    // Byte/page write of tx[0..n-1]; model stores and predicts strobes
    task automatic wr_txn(input logic [7:0] a, input int n);
        logic ack;
        logic [15:0] expq[$];
        wq.delete();
        bus_start();
        send_byte({7'h50, 1'b0}, ack);
        chk("wr_dev_ack", 32'(ack), 32'(IIC_ACK));
        chk("wr_busy_hi", 32'(busy), 32'd1);
        send_byte(a, ack);
        chk("wr_addr_ack", 32'(ack), 32'(IIC_ACK));
        mptr = a;
        for (int i = 0; i < n; i++) begin
            send_byte(tx[i], ack);
            chk("wr_data_ack", 32'(ack), 32'(IIC_ACK));
            expq.push_back({mptr[7:0], tx[i]});
            mmem[mptr] = tx[i];
            mptr = (mptr + AI) % 256;
        end
        bus_stop();
        hw(4);
        chk("wr_busy_lo", 32'(busy), 32'd0);
        chk("wr_cnt", 32'(wq.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < wq.size()) chk("wr_strobe", 32'(wq[i]), 32'(expq[i]));
    endtask

    // Random read: set pointer, repeated START, read n bytes, NACK the last
    task automatic rd_txn(input logic [7:0] a, input int n);
        logic ack;
        logic [7:0] d;
        bus_start();
        send_byte({7'h50, 1'b0}, ack);
        chk("rd_devw_ack", 32'(ack), 32'(IIC_ACK));
        send_byte(a, ack);
        chk("rd_addr_ack", 32'(ack), 32'(IIC_ACK));
        mptr = a;
        bus_start();
        send_byte({7'h50, 1'b1}, ack);
        chk("rd_devr_ack", 32'(ack), 32'(IIC_ACK));
        for (int i = 0; i < n; i++) begin
            recv_byte(d, (i == n - 1) ? IIC_NACK : IIC_ACK);
            chk("rd_data", 32'(d), 32'(mmem[mptr]));
            mptr = (mptr + AI) % 256;
        end
        hw(4);
        chk("rd_release", 32'(sda_oe), 32'd0);
        chk("rd_busy_lo", 32'(busy), 32'd0);
        chk("rd_idle", 32'(dut.r_state), 32'(IDLE));
        bus_stop();
        hw(4);
    endtask

    initial begin
        logic ack;
        logic [7:0] d, a;
        int n;

        hw(4);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("rst_ptr", 32'(dut.r_ptr), 32'd0);
        s_rst = 1'b0;
        hw(4);

        tx[0] = 8'hA5;
        wr_txn(8'h10, 1);
        rd_txn(8'h10, 1);

        // Foreign device address: target must stay silent
        oe_seen = 1'b0;
        wq.delete();
        bus_start();
        send_byte({7'h51, 1'b0}, ack);
        chk("nak_ack", 32'(ack), 32'(IIC_NACK));
        chk("nak_busy", 32'(busy), 32'd0);
        send_byte(8'h10, ack);
        send_byte(8'h77, ack);
        bus_stop();
        hw(4);
        chk("nak_oe", 32'(oe_seen), 32'd0);
        chk("nak_wr", 32'(wq.size()), 32'd0);
        chk("nak_busy_end", 32'(busy), 32'd0);

        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
        wr_txn(8'hFE, 3);
        rd_txn(8'hFE, 3);

        // STOP inside a data byte discards it
        wq.delete();
        bus_start();
        send_byte({7'h50, 1'b0}, ack);
        send_byte(8'h10, ack);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_stop();
        hw(4);
        chk("part_wr", 32'(wq.size()), 32'd0);
        chk("part_idle", 32'(dut.r_state), 32'(IDLE));
        chk("part_busy", 32'(busy), 32'd0);
        rd_txn(8'h10, 1);

        // Current-address read continues from the pointer left by the last read
        a = 8'($urandom);
        tx[0] = 8'($urandom); tx[1] = 8'($urandom);
        wr_txn(a, 2);
        rd_txn(a, 1);
        bus_start();
        send_byte({7'h50, 1'b1}, ack);
        chk("cur_ack", 32'(ack), 32'(IIC_ACK));
        recv_byte(d, IIC_NACK);
        chk("cur_data", 32'(d), 32'(mmem[mptr]));
        mptr = (mptr + AI) % 256;
        bus_stop();
        hw(4);

        for (int k = 0; k < 6; k++) begin
            a = 8'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
            wr_txn(a, n);
            rd_txn(a, $urandom_range(1, n));
        end

        // Reset while the target is driving read data
        tx[0] = 8'h00;
        wr_txn(8'h40, 1);
        bus_start();
        send_byte({7'h50, 1'b0}, ack);
        send_byte(8'h40, ack);
        bus_start();
        send_byte({7'h50, 1'b1}, ack);
        chk("rst_rd_ack", 32'(ack), 32'(IIC_ACK));
        chk("rst_rd_drive", 32'(sda_oe), 32'd1);
        s_rst = 1'b1;
        @(negedge s_clk);
        chk("rst_rd_oe", 32'(sda_oe), 32'd0);
        chk("rst_rd_idle", 32'(dut.r_state), 32'(IDLE));
        s_rst = 1'b0;
        mptr = 0;
        m_sda = 1'b1; hw(Q); m_scl = 1'b1; hw(Q);
        chk("rst_ignore", 32'(dut.r_state), 32'(IDLE));
        tx[0] = 8'($urandom);
        wr_txn(8'h41, 1);
        rd_txn(8'h41, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
